multi_lane_tx_serializer: RTL

MULTI_LANE_TX_SERIALIZER -- requirements
Module: multi_lane_tx_serializer

---
 rtl/multi_lane_tx_serializer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multi_lane_tx_serializer.sv
// multi_lane_tx_serializer
// Parallel-to-serial transmitter for LANES independent lanes sharing one
// bit-rate clock. A one-entry holding buffer accepts a word for all lanes;
// each symbol is shifted out over SYM_W cycles through registered P/N legs.
// Optional feature macro: TX_POLARITY_INV_EN adds per-lane polarity inversion
// through the Lane_Pol_Inv input, sampled whenever a symbol is loaded.
module multi_lane_tx_serializer #(
    parameter int LANES     = 4,
    parameter int SYM_W     = 10,
    parameter int LSB_FIRST = 1
) (
    input  logic                     Bit_Rate_Clk,
    input  logic                     Rst,
    input  logic [LANES*SYM_W-1:0]   Data_in,
    input  logic                     Data_Valid,
    output logic                     Data_Ready,
    input  logic                     TxElecIdle,
`ifdef TX_POLARITY_INV_EN
    input  logic [LANES-1:0]         Lane_Pol_Inv,
`endif
    output logic [LANES-1:0]         TX_Out_P,
    output logic [LANES-1:0]         TX_Out_N,
    output logic                     Underrun,
    output logic                     Sym_Strobe
);

    localparam int               CNT_W    = $clog2(SYM_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_W - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [LANES*SYM_W-1:0]        hold_q, hold_d;
    logic                          hold_full_q, hold_full_d;
    logic [LANES-1:0][SYM_W-1:0]   sh_q, sh_d;
    logic [LANES-1:0]              pol_q, pol_d;
    logic                          underrun_pend_q, underrun_pend_d;
    logic [LANES-1:0]              tx_p_q, tx_p_d;
    logic [LANES-1:0]              tx_n_q, tx_n_d;
    logic                          underrun_q, underrun_d;
    logic                          sym_strobe_q, sym_strobe_d;

    logic                          accept;
    logic                          load;
    logic [LANES-1:0]              cur_bit;

    // Ready depends only on registered state, never on Data_Valid.
    assign Data_Ready = ~hold_full_q;
    assign accept     = Data_Valid & ~hold_full_q;

    // Next-state logic: FSM, bit counter, holding buffer, shift registers and output stage.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d         = state_q;
        cnt_d           = cnt_q;
        hold_d          = hold_q;
        hold_full_d     = hold_full_q;
        sh_d            = sh_q;
        pol_d           = pol_q;
        underrun_pend_d = 1'b0;
        load            = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q && !TxElecIdle) begin
                    load    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_q == CNT_LAST) begin
                    if (hold_full_q && !TxElecIdle) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        // An idle request is a deliberate stop, not an underrun.
                        underrun_pend_d = ~hold_full_q & ~TxElecIdle;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cnt_d       = '0;
            hold_full_d = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                sh_d[k] = hold_q[k*SYM_W +: SYM_W];
            end
`ifdef TX_POLARITY_INV_EN
            pol_d = Lane_Pol_Inv;
`else
            pol_d = '0;
`endif
        end else if (state_q == ACTIVE) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            for (int k = 0; k < LANES; k++) begin
                sh_d[k] = (LSB_FIRST != 0) ? (sh_q[k] >> 1) : (sh_q[k] << 1);
            end
        end

        // Load requires a full buffer, so accept and unload never coincide.
        if (accept) begin
            hold_d      = Data_in;
            hold_full_d = 1'b1;
        end

        for (int k = 0; k < LANES; k++) begin
            cur_bit[k] = (LSB_FIRST != 0) ? sh_q[k][0] : sh_q[k][SYM_W-1];
        end

        if (state_q == ACTIVE) begin
            tx_p_d = cur_bit ^ pol_q;
            tx_n_d = ~(cur_bit ^ pol_q);
        end else begin
            tx_p_d = '0;
            tx_n_d = '0;
        end
        sym_strobe_d = (state_q == ACTIVE) && (cnt_q == '0);
        underrun_d   = underrun_pend_q;
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge Bit_Rate_Clk or posedge Rst) begin
        if (Rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            // NOTE: shift registers are reset too, so a partial symbol can never leak after reset.
            sh_q            <= '0;
            pol_q           <= '0;
            underrun_pend_q <= 1'b0;
            tx_p_q          <= '0;
            tx_n_q          <= '0;
            underrun_q      <= 1'b0;
            sym_strobe_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            sh_q            <= sh_d;
            pol_q           <= pol_d;
            underrun_pend_q <= underrun_pend_d;
            tx_p_q          <= tx_p_d;
            tx_n_q          <= tx_n_d;
            underrun_q      <= underrun_d;
            sym_strobe_q    <= sym_strobe_d;
        end
    end

    assign TX_Out_P   = tx_p_q;
    assign TX_Out_N   = tx_n_q;
    assign Underrun   = underrun_q;
    assign Sym_Strobe = sym_strobe_q;

endmodule
